// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: fetch-mux selects, branch
// condition codes, 2-bit direction-counter states and the BTB entry layout.
package bp_pkg;

  localparam logic [1:0] PCSEL_SEQ   = 2'b00;
  localparam logic [1:0] PCSEL_PRED  = 2'b01;
  localparam logic [1:0] PCSEL_REDIR = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Control bits of one BTB entry; tag and target live in parallel storage
  // because their widths depend on the top-level parameters.
  typedef struct packed {
    logic valid;
    ctr_e ctr;
    logic is_jump;
  } btb_entry_t;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    if (taken && cur != ST) begin
      nxt = ctr_e'(cur + 2'd1);
    end else if (!taken && cur != SNT) begin
      nxt = ctr_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

  function automatic logic ctr_predicts_taken(input ctr_e cur);
    return (cur == WT) || (cur == ST);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch evaluator: maps funct3 and the rs1-rs2 ALU flags to a
// taken decision. funct3 codes that are not branches report f3_valid=0.
module branch_cond
  import bp_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zf,
  input  logic       cf,
  input  logic       vf,
  input  logic       sf,
  output logic       taken,
  output logic       f3_valid
);

  always_comb begin
    taken    = 1'b0;
    f3_valid = 1'b1;
    case (funct3)
      F3_BEQ:  taken = zf;
      F3_BNE:  taken = ~zf;
      F3_BLT:  taken = (sf != vf);
      F3_BGE:  taken = (sf == vf);
      F3_BLTU: taken = ~cf;
      F3_BGEU: taken = cf;
      default: f3_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters for IF-stage prediction,
// EX-stage resolution of branches/jumps, mispredict redirect and perf counters.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic             zf,
  input  logic             cf,
  input  logic             vf,
  input  logic             sf,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic [1:0]       pc_sel,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  btb_entry_t      w_meta   [ENTRIES];
  logic [TAG_W-1:0] w_tag   [ENTRIES];
  logic [XLEN-1:0] w_target [ENTRIES];

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_if_hit;
  logic             w_ex_hit;
  logic             w_ex_act;
  logic             w_cond_taken;
  logic             w_f3_valid;
  logic             w_taken;
  logic             w_upd;
  logic             w_mispred;
  logic             w_unused;

  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign w_unused = ^if_pc[1:0];

  // ---------------- IF-stage lookup (reads pre-update state, no bypass)
  assign w_if_hit = if_valid & ~rst & w_meta[w_if_idx].valid
                  & (w_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = w_if_hit & (w_meta[w_if_idx].is_jump
                                   | ctr_predicts_taken(w_meta[w_if_idx].ctr));
  assign pred_target = pred_taken ? w_target[w_if_idx] : '0;

  // ---------------- EX-stage resolution
  branch_cond u_cond (
    .funct3   (ex_funct3),
    .zf       (zf),
    .cf       (cf),
    .vf       (vf),
    .sf       (sf),
    .taken    (w_cond_taken),
    .f3_valid (w_f3_valid)
  );

  assign w_ex_act  = ex_valid & ~rst;
  assign w_taken   = w_ex_act & (ex_is_jal | ex_is_jalr | (ex_is_branch & w_cond_taken));
  // Non-branch funct3 codes are still counted but never touch the table.
  assign w_upd     = w_ex_act & (ex_is_jal | ex_is_jalr | (ex_is_branch & w_f3_valid));
  assign w_ex_hit  = w_meta[w_ex_idx].valid & (w_tag[w_ex_idx] == w_ex_tag);
  assign w_mispred = w_ex_act & ((w_taken != ex_pred_taken)
                               | (w_taken & (ex_target != ex_pred_target)));

  assign redirect    = w_mispred;
  assign redirect_pc = !w_ex_act ? '0 : (w_taken ? ex_target : ex_pc + XLEN'(4));
  assign pc_sel      = w_mispred ? PCSEL_REDIR : (pred_taken ? PCSEL_PRED : PCSEL_SEQ);

  // ---------------- BTB storage, one register set per entry
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    btb_entry_t       r_meta;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_target;
    logic             w_sel;

    assign w_sel = w_upd & (w_ex_idx == IDX_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_meta <= '{valid: 1'b0, ctr: WNT, is_jump: 1'b0};
      end else if (w_sel) begin
        if (w_ex_hit) begin
          r_meta.ctr <= ctr_next(r_meta.ctr, w_taken);
          if (w_taken) begin
            r_target <= ex_target;
          end
        end else if (w_taken) begin
          r_meta   <= '{valid: 1'b1, ctr: WT, is_jump: ex_is_jal | ex_is_jalr};
          r_tag    <= w_ex_tag;
          r_target <= ex_target;
        end
      end
    end

    assign w_meta[gi]   = r_meta;
    assign w_tag[gi]    = r_tag;
    assign w_target[gi] = r_target;
  end

  // ---------------- Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_ex_act && !(&r_branch_cnt)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_mispred && !(&r_mispred_cnt)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed plus randomized bench for branch_predict_unit, checked against a
// behavioural BTB model driven by operand comparisons rather than flags.
module tb_branch_predict_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  localparam int K_NONE = 0;
  localparam int K_BR   = 1;
  localparam int K_JAL  = 2;
  localparam int K_JALR = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_valid;
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]       ex_funct3;
  logic             zf, cf, vf, sf;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic [1:0]       pc_sel;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  always #5 clk = ~clk;

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .zf(zf), .cf(cf), .vf(vf), .sf(sf),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_sel(pc_sel), .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  int tests = 0;
  int fails = 0;
  int ncyc  = 0;

  // Behavioural model: each slot remembers the full PC it was trained on.
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_jump  [ENTRIES];
  int          m_bcnt, m_mcnt;

  // DUT values captured at the sampling point of the last transaction.
  logic        s_ptaken, s_redirect;
  logic [31:0] s_ptgt, s_rpc;
  logic [1:0]  s_sel;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit same_block(input logic [31:0] a, input logic [31:0] b);
    return (a / (4 * ENTRIES)) == (b / (4 * ENTRIES));
  endfunction

  task automatic model_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int s;
    s = slot_of(pc);
    t = 1'b0;
    tg = 32'h0;
    if (m_valid[s] && same_block(m_pc[s], pc) && (m_jump[s] || m_ctr[s] >= 2)) begin
      t = 1'b1;
      tg = m_tgt[s];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
      m_jump[i]  = 1'b0;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive_idle();
    if_valid = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0;
    ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0; ex_funct3 = '0;
    zf = 1'b0; cf = 1'b0; vf = 1'b0; sf = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic do_reset(input int cycles);
    drive_idle();
    rst = 1'b1;
    if_valid = 1'b1;
    if_pc = 32'h100;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("rst_pred_taken", 32'(pred_taken), 32'h0);
      check("rst_pred_target", pred_target, 32'h0);
      check("rst_pc_sel", 32'(pc_sel), 32'h0);
      check("rst_redirect", 32'(redirect), 32'h0);
      check("rst_redirect_pc", redirect_pc, 32'h0);
      if (c > 0) begin
        check("rst_branch_cnt", 32'(branch_cnt), 32'h0);
        check("rst_mispred_cnt", 32'(mispred_cnt), 32'h0);
      end
      @(posedge clk);
      model_clear();
      #1;
    end
    rst = 1'b0;
    $display("[TB] reset applied for %0d cycles", cycles);
  endtask

  // One clock of stimulus: drive after the edge, check at negedge, then
  // advance the model on the following rising edge.
  task automatic cyc(input bit iv, input logic [31:0] ipc, input bit ev, input int kind,
                     input logic [2:0] f3, input logic [31:0] epc, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [31:0] tgt, input bit ovr,
                     input bit opt_in, input logic [31:0] optg_in);
    bit          opt, pt, at, mp, cfi, ex_hit;
    logic [31:0] optg, ptg, rpc, diff;
    logic [1:0]  sel;
    int          s;

    if (ovr) begin
      opt = opt_in; optg = optg_in;
    end else begin
      model_lookup(epc, opt, optg);
    end
    diff = rs1 - rs2;

    if_valid = iv; if_pc = ipc; ex_valid = ev; ex_pc = epc;
    ex_is_branch = (kind == K_BR); ex_is_jal = (kind == K_JAL); ex_is_jalr = (kind == K_JALR);
    ex_funct3 = f3; ex_target = tgt; ex_pred_taken = opt; ex_pred_target = optg;
    zf = (diff == 32'h0);
    cf = (rs1 >= rs2);
    sf = diff[31];
    vf = (rs1[31] != rs2[31]) && (diff[31] != rs1[31]);

    at = 1'b0;
    if (kind == K_JAL || kind == K_JALR) begin
      at = 1'b1;
    end else if (kind == K_BR) begin
      case (f3)
        3'd0: at = (rs1 == rs2);
        3'd1: at = (rs1 != rs2);
        3'd4: at = ($signed(rs1) < $signed(rs2));
        3'd5: at = ($signed(rs1) >= $signed(rs2));
        3'd6: at = (rs1 < rs2);
        3'd7: at = (rs1 >= rs2);
        default: at = 1'b0;
      endcase
    end
    at  = at && ev;
    cfi = ev && (kind == K_JAL || kind == K_JALR || (kind == K_BR && f3 != 3'd2 && f3 != 3'd3));

    if (iv) begin
      model_lookup(ipc, pt, ptg);
    end else begin
      pt = 1'b0; ptg = 32'h0;
    end
    mp  = ev && ((at != opt) || (at && tgt != optg));
    rpc = !ev ? 32'h0 : (at ? tgt : epc + 32'd4);
    sel = mp ? 2'b10 : (pt ? 2'b01 : 2'b00);

    @(negedge clk);
    s_ptaken = pred_taken; s_ptgt = pred_target; s_sel = pc_sel;
    s_redirect = redirect; s_rpc = redirect_pc;
    check("pred_taken", 32'(pred_taken), 32'(pt));
    check("pred_target", pred_target, ptg);
    check("pc_sel", 32'(pc_sel), 32'(sel));
    check("redirect", 32'(redirect), 32'(mp));
    check("redirect_pc", redirect_pc, rpc);
    check("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
    check("mispred_cnt", 32'(mispred_cnt), 32'(m_mcnt));
    $display("[TB] cyc %0d if=%0b/%h pt=%0b/%h ex=%0b k=%0d f3=%0d pc=%h tgt=%h act=%0b mp=%0b rpc=%h sel=%0d",
             ncyc, iv, ipc, pred_taken, pred_target, ev, kind, f3, epc, tgt, at, redirect,
             redirect_pc, pc_sel);
    ncyc++;

    @(posedge clk);
    if (ev) begin
      m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
      if (mp) m_mcnt = (m_mcnt < CMAX) ? m_mcnt + 1 : CMAX;
    end
    if (cfi) begin
      s = slot_of(epc);
      ex_hit = m_valid[s] && same_block(m_pc[s], epc);
      if (ex_hit) begin
        m_ctr[s] = at ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
        if (at) m_tgt[s] = tgt;
      end else if (at) begin
        m_valid[s] = 1'b1; m_pc[s] = epc; m_tgt[s] = tgt; m_ctr[s] = 2;
        m_jump[s] = (kind == K_JAL || kind == K_JALR);
      end
    end
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    cyc(1'b1, pc, 1'b0, K_NONE, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic [31:0] pc, input int kind, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] tgt);
    cyc(1'b0, 32'h0, 1'b1, kind, f3, pc, rs1, rs2, tgt, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rand_cycle();
    logic [31:0] ipc, epc, rs1, rs2, tgt;
    int          kind;
    bit          ovr;
    ipc  = 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 15)) << 2);
    epc  = 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 15)) << 2);
    rs1  = $urandom;
    rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
    if ($urandom_range(0, 7) == 0) rs1 = 32'h8000_0000;
    tgt  = 32'h2000 + (32'($urandom_range(0, 7)) << 2);
    kind = ($urandom_range(0, 9) < 7) ? K_BR : ($urandom_range(0, 1) == 1 ? K_JAL : K_JALR);
    ovr  = ($urandom_range(0, 7) == 0);
    cyc($urandom_range(0, 4) != 0, ipc, $urandom_range(0, 9) != 0, kind,
        3'($urandom_range(0, 7)), epc, rs1, rs2, tgt, ovr, 1'($urandom_range(0, 1)), tgt);
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    model_clear();
    do_reset(2);

    // Cold lookup.
    lookup(32'h100);
    check("tp_cold_pred", 32'(s_ptaken), 32'h0);
    check("tp_cold_sel", 32'(s_sel), 32'h0);

    // beq taken, predicted not-taken: allocate and redirect.
    cyc(1'b0, 32'h0, 1'b1, K_BR, 3'd0, 32'h100, 32'd5, 32'd5, 32'h140, 1'b1, 1'b0, 32'h0);
    check("tp_beq_redirect", 32'(s_redirect), 32'h1);
    check("tp_beq_rpc", s_rpc, 32'h140);
    check("tp_beq_sel", 32'(s_sel), 32'h2);
    lookup(32'h100);
    check("tp_beq_pred", 32'(s_ptaken), 32'h1);
    check("tp_beq_ptgt", s_ptgt, 32'h140);

    // Three not-taken resolutions: only the first mispredicts.
    resolve(32'h100, K_BR, 3'd0, 32'd1, 32'd2, 32'h140);
    check("tp_nt1_redirect", 32'(s_redirect), 32'h1);
    check("tp_nt1_rpc", s_rpc, 32'h104);
    resolve(32'h100, K_BR, 3'd0, 32'd1, 32'd2, 32'h140);
    check("tp_nt2_redirect", 32'(s_redirect), 32'h0);
    resolve(32'h100, K_BR, 3'd0, 32'd1, 32'd2, 32'h140);
    check("tp_nt3_redirect", 32'(s_redirect), 32'h0);
    lookup(32'h100);
    check("tp_nt_pred", 32'(s_ptaken), 32'h0);

    // jalr target change.
    resolve(32'h200, K_JALR, 3'd0, 32'd0, 32'd0, 32'h300);
    cyc(1'b0, 32'h0, 1'b1, K_JALR, 3'd0, 32'h200, 32'd0, 32'd0, 32'h380, 1'b1, 1'b1, 32'h300);
    check("tp_jalr_redirect", 32'(s_redirect), 32'h1);
    check("tp_jalr_rpc", s_rpc, 32'h380);
    lookup(32'h200);
    check("tp_jalr_ptgt", s_ptgt, 32'h380);

    // Aliasing at index 0 and same-cycle lookup/update.
    resolve(32'h100, K_BR, 3'd0, 32'd7, 32'd7, 32'h150);
    resolve(32'h140, K_BR, 3'd1, 32'd7, 32'd8, 32'h160);
    lookup(32'h100);
    check("tp_alias_miss", 32'(s_ptaken), 32'h0);
    cyc(1'b1, 32'h140, 1'b1, K_BR, 3'd1, 32'h140, 32'd1, 32'd9, 32'h180, 1'b0, 1'b0, 32'h0);
    check("tp_same_cycle_old", s_ptgt, 32'h160);
    lookup(32'h140);
    check("tp_same_cycle_new", s_ptgt, 32'h180);

    // Unsigned compares and a non-branch funct3.
    resolve(32'h404, K_BR, 3'd6, 32'd3, 32'hFFFF_FFF0, 32'h500);
    resolve(32'h408, K_BR, 3'd6, 32'hFFFF_FFF0, 32'd3, 32'h500);
    resolve(32'h40C, K_BR, 3'd7, 32'hFFFF_FFF0, 32'd3, 32'h500);
    resolve(32'h418, K_BR, 3'd7, 32'd3, 32'hFFFF_FFF0, 32'h500);
    resolve(32'h410, K_BR, 3'd2, 32'd3, 32'd3, 32'h500);
    lookup(32'h404);
    check("tp_bltu_pred", 32'(s_ptaken), 32'h1);
    lookup(32'h410);
    check("tp_f3_010_noalloc", 32'(s_ptaken), 32'h0);

    // Signed compares across the sign boundary.
    resolve(32'h420, K_BR, 3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 32'h600);
    resolve(32'h424, K_BR, 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h600);
    resolve(32'h428, K_JAL, 3'd0, 32'd0, 32'd0, 32'h700);

    // Mid-stream reset clears table and counters.
    do_reset(2);
    lookup(32'h404);
    check("tp_post_reset_pred", 32'(s_ptaken), 32'h0);

    for (int i = 0; i < 100; i++) rand_cycle();
    do_reset(2);
    for (int i = 0; i < 320; i++) rand_cycle();
    lookup(32'h1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
